axi4_slave_mem: RTL and testbench
=================================

Name: axi4_slave_mem

Overview:
AXI4 slave memory endpoint that sits directly downstream of the team's AXI4 master and consumes its read and write channels. It services INCR bursts from an internal word-addressed register-array memory. It returns read data/responses and write responses, and is the target the master and data generator are verified against.

Parameters:
DEPTH, 256, number of 32-bit words in the memory (power of two, >= 4)
ADDR_WIDTH, 32, width of araddr/awaddr

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  asynchronous active-high reset
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  ADDR_WIDTH  read burst start byte address
arlen  in  8  read beats minus one
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  32  read data
rresp  out  2  read response (OKAY 00 / SLVERR 10)
rlast  out  1  final read beat
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  ADDR_WIDTH  write burst start byte address
awlen  in  8  write beats minus one
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  final write beat (checked, not used for termination)
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  write response

Behaviour:
- Interface: one clock aclk; reset areset is asynchronous, active-high.
- Reset: all outputs 0; FSMs to IDLE; beat counters/addresses 0. Memory contents are not reset. arready/awready rise on the first aclk edge after areset deasserts.
- Burst type is INCR only, 4 bytes/beat; addr[1:0] ignored. Beat address += 4 per beat, 32-bit modulo, no 4KB boundary logic.
- Range check per beat: word index = addr>>2; in range iff < DEPTH.
- Read FSM R_IDLE/R_DATA: arready=1 only in R_IDLE.
  - arvalid&&arready captures araddr/arlen, count=0, goes to R_DATA; rvalid asserts on the next cycle (1-cycle latency).
  - In R_DATA: rdata = mem[idx] if in range, else 0 with rresp=SLVERR; rlast = (count==len).
  - rvalid&&rready on the last beat goes to R_IDLE (arready 1 next cycle); otherwise address and count advance.
  - rdata/rresp/rlast hold stable while rvalid&&!rready.
- Write FSM W_IDLE/W_DATA/W_RESP: awready=1 only in W_IDLE.
  - Handshake captures awaddr/awlen and clears the error flag.
  - In W_DATA wready=1; each wvalid&&wready commits wstrb-selected bytes at the edge if in range, else drops the beat and sets the error flag.
  - wlast != (count==len) sets the error flag.
  - After beat len (always awlen+1 beats): W_RESP, bvalid=1, bresp=SLVERR if error flag else OKAY; bvalid&&bready goes to W_IDLE.
- One outstanding burst per direction. Read and write channels run concurrently.
- Same-cycle read beat and write beat to the same word: read returns old data; the write takes effect next cycle.
- arlen=0/awlen=0: single beat, rlast=1 on that beat.
- areset mid-burst: burst abandoned immediately, valids drop asynchronously, writes already committed persist, no response issued.

Decomposition:
- Package axi4_pkg: axi_resp_t (2b) with RESP_OKAY=2'b00, RESP_SLVERR=2'b10; axi_len_t (8b); data_t (32b); BYTES_PER_BEAT=4.
- One sub-module, axi4_beat_tracker: holds beat address/count/len and outputs idx, in_range, last; instantiated once for read and once for write.

Test Plan:
1. Reset release -> arready=awready=1 next edge. Write 0x10 len0 data 0xDEADBEEF wstrb 0xF wlast=1 -> bresp 00. Read 0x10 len0 -> rvalid one cycle after AR handshake, rdata 0xDEADBEEF, rlast=1, rresp 00.
2. Write 0x0 len3 data 1,2,3,4. Read 0x0 len3 with rready pattern 1,0,1,0,... -> beats 1,2,3,4, rlast only on 4th, outputs stable during stalls.
3. Write 0x20 0xFFFFFFFF, then 0x00000000 with wstrb 0101 -> read returns 0xFF00FF00.
4. DEPTH=256, read 0x3F8 len3 -> beats 0,1 OKAY with stored data, beats 2,3 SLVERR with rdata 0. Same write -> bresp SLVERR, words 0x3F8/0x3FC updated.
5. Write len3 with wlast asserted at beat 1 -> still 4 beats accepted, bresp SLVERR.
6. areset asserted during beat 2 of a len7 read -> rvalid=0 immediately; after release arready=1 next edge, and a fresh read 0x0 len0 returns 1.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 types and constants for the slave memory endpoint.
package axi4_pkg;

   typedef logic [1:0]  axi_resp_t;
   typedef logic [7:0]  axi_len_t;
   typedef logic [31:0] data_t;

   localparam axi_resp_t RESP_OKAY      = 2'b00;
   localparam axi_resp_t RESP_SLVERR    = 2'b10;
   localparam int        BYTES_PER_BEAT = 4;

   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

endpackage

// File: rtl/axi4_beat_tracker.sv
// Tracks the running beat address and count of one INCR burst and reports
// the word index, whether it falls inside the memory, and the last beat.
module axi4_beat_tracker
   import axi4_pkg::*;
#(
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     load_i,
   input  logic [ADDR_WIDTH-1:0]    addr_i,
   input  axi_len_t                 len_i,
   input  logic                     adv_i,
   output logic [$clog2(DEPTH)-1:0] idx_o,
   output logic                     in_range_o,
   output logic                     last_o
);

   logic [ADDR_WIDTH-1:0] addr_q;
   axi_len_t              cnt_q;
   axi_len_t              len_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q <= '0;
         cnt_q  <= '0;
         len_q  <= '0;
      end else if (load_i) begin
         addr_q <= addr_i;
         cnt_q  <= '0;
         len_q  <= len_i;
      end else if (adv_i) begin
         // Plain modulo-2^ADDR_WIDTH increment; no 4KB boundary handling.
         addr_q <= addr_q + ADDR_WIDTH'(BYTES_PER_BEAT);
         cnt_q  <= cnt_q + 8'd1;
      end
   end

   assign idx_o      = $clog2(DEPTH)'(addr_q >> 2);
   assign in_range_o = (addr_q >> 2) < ADDR_WIDTH'(DEPTH);
   assign last_o     = (cnt_q == len_q);

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 INCR-burst slave backed by a word-addressed register array; read and
// write channels run independently with one outstanding burst each.
module axi4_slave_mem
   import axi4_pkg::*;
#(
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  arvalid,
   output logic                  arready,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  axi_len_t              arlen,
   output logic                  rvalid,
   input  logic                  rready,
   output data_t                 rdata,
   output axi_resp_t             rresp,
   output logic                  rlast,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  axi_len_t              awlen,
   input  logic                  wvalid,
   output logic                  wready,
   input  data_t                 wdata,
   input  logic [3:0]            wstrb,
   input  logic                  wlast,
   output logic                  bvalid,
   input  logic                  bready,
   output axi_resp_t             bresp
);

   localparam int IDX_W = $clog2(DEPTH);

   data_t            mem_q [DEPTH];
   r_state_t         r_state_q;
   w_state_t         w_state_q;
   logic             arready_q, rvalid_q, rhold_q;
   logic             awready_q, wready_q, bvalid_q, werr_q;
   axi_resp_t        bresp_q;
   data_t            rhold_data_q;
   logic [IDX_W-1:0] r_idx, w_idx;
   logic             r_in_range, r_last, w_in_range, w_last;

   logic  ar_fire, r_fire, aw_fire, w_fire, w_beat_err;
   data_t rdata_cur;

   assign ar_fire    = arvalid && arready_q;
   assign r_fire     = rvalid_q && rready;
   assign aw_fire    = awvalid && awready_q;
   assign w_fire     = wvalid && wready_q;
   assign rdata_cur  = r_in_range ? mem_q[r_idx] : '0;
   assign w_beat_err = !w_in_range || (wlast != w_last);

   axi4_beat_tracker #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_trk (
      .clk_i(aclk), .rst_i(areset), .load_i(ar_fire), .addr_i(araddr), .len_i(arlen),
      .adv_i(r_fire), .idx_o(r_idx), .in_range_o(r_in_range), .last_o(r_last)
   );

   axi4_beat_tracker #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_trk (
      .clk_i(aclk), .rst_i(areset), .load_i(aw_fire), .addr_i(awaddr), .len_i(awlen),
      .adv_i(w_fire), .idx_o(w_idx), .in_range_o(w_in_range), .last_o(w_last)
   );

   // Memory is deliberately not reset; out-of-range beats are dropped.
   always_ff @(posedge aclk) begin
      if (w_fire && w_in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem_q[w_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (rvalid_q && !rready && !rhold_q) rhold_data_q <= rdata_cur;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rhold_q   <= 1'b0;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               if (ar_fire) begin
                  r_state_q <= R_DATA;
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               // A stalled beat freezes its data so a concurrent write cannot change it.
               rhold_q <= !rready;
               if (rready && r_last) begin
                  r_state_q <= R_IDLE;
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  rhold_q   <= 1'b0;
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         werr_q    <= 1'b0;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               if (aw_fire) begin
                  w_state_q <= W_DATA;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  werr_q    <= 1'b0;
               end else begin
                  awready_q <= 1'b1;
               end
            end
            W_DATA: begin
               if (wvalid) begin
                  if (w_beat_err) werr_q <= 1'b1;
                  // Termination follows the beat count, not wlast.
                  if (w_last) begin
                     w_state_q <= W_RESP;
                     wready_q  <= 1'b0;
                     bvalid_q  <= 1'b1;
                     bresp_q   <= (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  w_state_q <= W_IDLE;
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rdata   = !rvalid_q ? '0 : (rhold_q ? rhold_data_q : rdata_cur);
   assign rresp   = (rvalid_q && !r_in_range) ? RESP_SLVERR : RESP_OKAY;
   assign rlast   = rvalid_q && r_last;
   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: single beats, stalled bursts, byte strobes,
// out-of-range beats, wlast mismatch and mid-burst reset.
module tb_axi4_slave_mem;
   import axi4_pkg::*;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
   logic        wlast = 1'b0, bready = 1'b0;
   logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
   axi_len_t    arlen = '0, awlen = '0;
   logic [3:0]  wstrb = '0;
   logic        arready, rvalid, rlast, awready, wready, bvalid;
   data_t       rdata;
   axi_resp_t   rresp, bresp;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] wd [16];
   logic [31:0] rd [16];
   logic [1:0]  rr [16];
   logic        rl [16];
   logic [1:0]  bresp_got;

   axi4_slave_mem #(.DEPTH(256), .ADDR_WIDTH(32)) dut (
      .aclk(aclk), .areset(areset),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] strb,
                           input int wlast_at);
      int n;
      awaddr = addr; awlen = 8'(len); awvalid = 1'b1; n = 0;
      while (awready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
      check("aw_ready", 32'(awready), 32'd1);
      @(posedge aclk); #1;
      awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         wvalid = 1'b1; wdata = wd[i]; wstrb = strb; wlast = (i == wlast_at);
         n = 0;
         while (wready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
         @(posedge aclk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b1; n = 0;
      while (bvalid !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
      check("b_valid", 32'(bvalid), 32'd1);
      bresp_got = bresp;
      @(posedge aclk); #1;
      bready = 1'b0;
      check("b_drop", 32'(bvalid), 32'd0);
   endtask

   task automatic do_read(input logic [31:0] addr, input int len, input bit stall);
      int          n, beat, cyc;
      bit          stalled;
      logic [31:0] hd;
      logic [1:0]  hr;
      logic        hl;
      araddr = addr; arlen = 8'(len); arvalid = 1'b1; n = 0;
      while (arready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
      check("ar_ready", 32'(arready), 32'd1);
      @(posedge aclk); #1;
      arvalid = 1'b0;
      check("r_latency", 32'(rvalid), 32'd1);
      beat = 0; cyc = 0; stalled = 1'b0; hd = '0; hr = '0; hl = 1'b0;
      while (beat <= len && cyc < 200) begin
         if (stalled) begin
            check("r_hold_data", rdata, hd);
            check("r_hold_resp", 32'(rresp), 32'(hr));
            check("r_hold_last", 32'(rlast), 32'(hl));
         end
         rready = stall ? (cyc % 2 == 0) : 1'b1;
         stalled = 1'b0;
         if (rvalid === 1'b1 && rready) begin
            rd[beat] = rdata; rr[beat] = rresp; rl[beat] = rlast;
            beat++;
         end else if (rvalid === 1'b1) begin
            stalled = 1'b1; hd = rdata; hr = rresp; hl = rlast;
         end
         @(posedge aclk); #1;
         cyc++;
      end
      rready = 1'b0;
      check("r_beats", 32'(beat), 32'(len + 1));
      check("r_idle", 32'(rvalid), 32'd0);
   endtask

   initial begin
      // Reset state and release
      repeat (2) @(posedge aclk);
      #1;
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_wready", 32'(wready), 32'd0);
      check("rst_bvalid", 32'(bvalid), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      @(negedge aclk);
      areset = 1'b0;
      #1;
      check("rel_arready_pre", 32'(arready), 32'd0);
      @(posedge aclk); #1;
      check("rel_arready", 32'(arready), 32'd1);
      check("rel_awready", 32'(awready), 32'd1);

      // Single-beat write and read
      wd[0] = 32'hDEADBEEF;
      do_write(32'h10, 0, 4'hF, 0);
      check("t1_bresp", 32'(bresp_got), 32'(RESP_OKAY));
      do_read(32'h10, 0, 1'b0);
      check("t1_rdata", rd[0], 32'hDEADBEEF);
      check("t1_rlast", 32'(rl[0]), 32'd1);
      check("t1_rresp", 32'(rr[0]), 32'(RESP_OKAY));

      // Four-beat burst, read back with rready toggling
      wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
      do_write(32'h0, 3, 4'hF, 3);
      check("t2_bresp", 32'(bresp_got), 32'(RESP_OKAY));
      do_read(32'h0, 3, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("t2_rdata", rd[i], 32'(i + 1));
         check("t2_rresp", 32'(rr[i]), 32'(RESP_OKAY));
         check("t2_rlast", 32'(rl[i]), 32'(i == 3));
      end

      // Byte strobes
      wd[0] = 32'hFFFFFFFF;
      do_write(32'h20, 0, 4'hF, 0);
      wd[0] = 32'h00000000;
      do_write(32'h20, 0, 4'b0101, 0);
      do_read(32'h20, 0, 1'b0);
      check("t3_rdata", rd[0], 32'hFF00FF00);

      // Burst crossing the end of memory
      wd[0] = 32'hA0A0A0A0; wd[1] = 32'hB1B1B1B1; wd[2] = 32'hC2C2C2C2; wd[3] = 32'hD3D3D3D3;
      do_write(32'h3F8, 3, 4'hF, 3);
      check("t4_bresp", 32'(bresp_got), 32'(RESP_SLVERR));
      do_read(32'h3F8, 3, 1'b0);
      check("t4_rdata0", rd[0], 32'hA0A0A0A0);
      check("t4_rdata1", rd[1], 32'hB1B1B1B1);
      check("t4_rdata2", rd[2], 32'h0);
      check("t4_rdata3", rd[3], 32'h0);
      check("t4_rresp0", 32'(rr[0]), 32'(RESP_OKAY));
      check("t4_rresp1", 32'(rr[1]), 32'(RESP_OKAY));
      check("t4_rresp2", 32'(rr[2]), 32'(RESP_SLVERR));
      check("t4_rresp3", 32'(rr[3]), 32'(RESP_SLVERR));
      check("t4_rlast3", 32'(rl[3]), 32'd1);

      // Early wlast still takes all four beats
      wd[0] = 32'd5; wd[1] = 32'd6; wd[2] = 32'd7; wd[3] = 32'd8;
      do_write(32'h40, 3, 4'hF, 1);
      check("t5_bresp", 32'(bresp_got), 32'(RESP_SLVERR));
      do_read(32'h40, 3, 1'b0);
      for (int i = 0; i < 4; i++) check("t5_rdata", rd[i], 32'(i + 5));

      // Reset during beat 2 of an eight-beat read
      araddr = 32'h0; arlen = 8'd7; arvalid = 1'b1;
      begin
         int n;
         n = 0;
         while (arready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
      end
      @(posedge aclk); #1;
      arvalid = 1'b0; rready = 1'b1;
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      check("t6_beat2_valid", 32'(rvalid), 32'd1);
      check("t6_beat2_data", rdata, 32'd3);
      areset = 1'b1;
      #1;
      check("t6_rvalid_drop", 32'(rvalid), 32'd0);
      check("t6_arready_rst", 32'(arready), 32'd0);
      rready = 1'b0;
      #2;
      areset = 1'b0;
      #1;
      check("t6_arready_pre", 32'(arready), 32'd0);
      @(posedge aclk); #1;
      check("t6_arready", 32'(arready), 32'd1);
      check("t6_awready", 32'(awready), 32'd1);
      do_read(32'h0, 0, 1'b0);
      check("t6_rdata", rd[0], 32'd1);
      check("t6_rlast", 32'(rl[0]), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
